id_stage_pipe: RTL and testbench

Parametrised pipelined instruction-decode stage. Sits between the IF/ID and ID/EX boundaries, with valid/ready handshakes on both sides. Decodes the opcode, reads a bypassed register file and resolves B/BR branches in ID. Detects load-use and flag hazards, inserts bubbles, honours downstream back-pressure and flush, and registers all decoded outputs into an ID/EX register.

---
 rtl/id_stage_pipe_pkg.sv | 71 +++++++
 rtl/id_stage_pipe_regfile_bypass.sv | 29 ++
 rtl/id_stage_pipe.sv | 103 ++++++++++
 tb/tb_id_stage_pipe.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pipe_pkg.sv
// id_stage_pipe_pkg: opcodes, aluop/branch/cc encodings, control field offsets and decoder
package id_stage_pipe_pkg;

    typedef enum logic [3:0] {
        OP_ADD, OP_PADDSB, OP_SUB, OP_AND, OP_NOR, OP_SLL, OP_SRL, OP_SRA,
        OP_LW, OP_SW, OP_LHB, OP_LLB, OP_B, OP_BR, OP_PCS, OP_HLT
    } opcode_e;

    typedef enum logic [1:0] {BR_NONE = 2'b00, BR_B = 2'b01, BR_BR = 2'b10} branch_e;

    typedef enum logic [2:0] {CC_NE, CC_EQ, CC_GT, CC_LT, CC_GE, CC_LE, CC_OV, CC_UN} cc_e;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_LHB  = 4'd8;
    localparam logic [3:0] ALU_LLB  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;

    localparam int CTRL_W        = 11;
    localparam int CTRL_REGWRITE = 10;
    localparam int CTRL_ALUSRC   = 9;
    localparam int CTRL_MEMEN    = 8;
    localparam int CTRL_MEMWR    = 7;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_ALUSEXT  = 5;
    localparam int CTRL_PCREAD   = 4;
    localparam int CTRL_ALUOP    = 0;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        branch_e           branch;
        logic              use1;
        logic              use2;
    } dec_t;

    // ctrl = {regwrite,alusrc,memenable,memwrite,memtoreg,alusext,pcread,aluop}
    function automatic dec_t decode(input opcode_e op);
        dec_t d;
        d = '0;
        case (op)
            OP_ADD, OP_PADDSB, OP_SUB, OP_AND, OP_NOR: begin
                d.ctrl = {7'b1000000, op}; d.use1 = 1'b1; d.use2 = 1'b1;
            end
            OP_SLL, OP_SRL, OP_SRA: begin d.ctrl = {7'b1100000, op}; d.use1 = 1'b1; end
            OP_LW:  begin d.ctrl = {7'b1110100, ALU_ADD}; d.use1 = 1'b1; end
            OP_SW:  begin d.ctrl = {7'b0111000, ALU_ADD}; d.use1 = 1'b1; d.use2 = 1'b1; end
            OP_LHB: begin d.ctrl = {7'b1100010, ALU_LHB}; d.use1 = 1'b1; end
            OP_LLB: begin d.ctrl = {7'b1100010, ALU_LLB}; d.use1 = 1'b1; end
            OP_B:   d.branch = BR_B;
            OP_BR:  begin d.branch = BR_BR; d.use1 = 1'b1; end
            OP_PCS: d.ctrl = {7'b1000001, ALU_PASS};
            default: d = '0;
        endcase
        return d;
    endfunction

    function automatic logic cc_true(input logic [2:0] cc, input logic [2:0] f);
        logic z, v, n;
        {z, v, n} = f;
        case (cc_e'(cc))
            CC_NE: return ~z;
            CC_EQ: return z;
            CC_GT: return ~z & ~n;
            CC_LT: return n;
            CC_GE: return z | ~n;
            CC_LE: return z | n;
            CC_OV: return v;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_pipe_regfile_bypass.sv
// id_stage_pipe_regfile_bypass: 2R1W register file, write-first bypass, R0 hardwired to zero
module id_stage_pipe_regfile_bypass #(
    parameter int DATA_W = 16,
    parameter int NREG   = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] mem [NREG];

    always_ff @(posedge clk or posedge rst)
        if (rst)
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        else if (we && waddr != '0)
            mem[waddr] <= wdata;

    assign rdata1 = raddr1 == '0 ? '0 : (we && waddr == raddr1) ? wdata : mem[raddr1];
    assign rdata2 = raddr2 == '0 ? '0 : (we && waddr == raddr2) ? wdata : mem[raddr2];

endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode, bypassed register read, branch resolve and hazard handling into ID/EX
module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int NREG    = 16,
    parameter int REG_AW  = 4,
    parameter int INSTR_W = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [DATA_W-1:0]  in_pc,
    input  logic [2:0]         flags,
    input  logic               flags_busy,
    input  logic               wb_en,
    input  logic [REG_AW-1:0]  wb_reg,
    input  logic [DATA_W-1:0]  wb_data,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [10:0]        out_ctrl,
    output logic [REG_AW-1:0]  out_src1,
    output logic [REG_AW-1:0]  out_src2,
    output logic [REG_AW-1:0]  out_dst,
    output logic [DATA_W-1:0]  out_data1,
    output logic [DATA_W-1:0]  out_data2,
    output logic [DATA_W-1:0]  out_imm,
    output logic [DATA_W-1:0]  out_pc,
    output logic               redirect_valid,
    output logic [DATA_W-1:0]  redirect_pc,
    output logic [CNT_W-1:0]   stall_count
);

    opcode_e           op;
    dec_t              dec;
    logic [REG_AW-1:0] rd, src1, src2;
    logic [DATA_W-1:0] rdata1, rdata2, imm, br_off;
    logic              ex_load, load_use, flag_stall, stall, load_en, fire;

    assign op   = opcode_e'(in_instr[15:12]);
    assign dec  = decode(op);
    assign rd   = in_instr[11:8];
    assign src1 = (op == OP_LHB || op == OP_LLB) ? rd : in_instr[7:4];
    assign src2 = op == OP_SW ? rd : in_instr[3:0];
    assign imm  = dec.ctrl[CTRL_ALUSEXT] ? {{(DATA_W-8){1'b0}}, in_instr[7:0]}
                                         : {{(DATA_W-4){in_instr[3]}}, in_instr[3:0]};

    id_stage_pipe_regfile_bypass #(.DATA_W(DATA_W), .NREG(NREG), .REG_AW(REG_AW)) u_rf (
        .clk(clk), .rst(rst), .we(wb_en), .waddr(wb_reg), .wdata(wb_data),
        .raddr1(src1), .raddr2(src2), .rdata1(rdata1), .rdata2(rdata2)
    );

    // A load in ID/EX cannot forward in time to a consumer still in ID
    assign ex_load    = out_valid & out_ctrl[CTRL_MEMEN] & ~out_ctrl[CTRL_MEMWR];
    assign load_use   = ex_load && out_dst != '0 &&
                        ((dec.use1 && src1 == out_dst) || (dec.use2 && src2 == out_dst));
    assign flag_stall = dec.branch != BR_NONE && flags_busy;
    assign stall      = load_use | flag_stall;
    assign load_en    = out_ready | ~out_valid;
    assign in_ready   = ~stall & load_en & ~flush;
    assign fire       = in_valid & in_ready;

    assign br_off         = {{(DATA_W-10){in_instr[8]}}, in_instr[8:0], 1'b0};
    assign redirect_pc    = dec.branch == BR_BR ? rdata1 : in_pc + br_off;
    assign redirect_valid = fire && dec.branch != BR_NONE && cc_true(in_instr[11:9], flags);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            out_src1  <= '0;
            out_src2  <= '0;
            out_dst   <= '0;
            out_data1 <= '0;
            out_data2 <= '0;
            out_imm   <= '0;
            out_pc    <= '0;
        end else if (flush)
            out_valid <= 1'b0;
        else if (fire) begin
            out_valid <= 1'b1;
            out_ctrl  <= dec.ctrl;
            out_src1  <= src1;
            out_src2  <= src2;
            out_dst   <= rd;
            out_data1 <= rdata1;
            out_data2 <= rdata2;
            out_imm   <= imm;
            out_pc    <= in_pc;
        end else if (load_en)
            out_valid <= 1'b0;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            stall_count <= '0;
        else if (in_valid && stall && !flush && !(&stall_count))
            stall_count <= stall_count + 1'b1;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed vectors with hand-computed expectations for id_stage_pipe
module tb_id_stage_pipe;

    logic        clk = 0, rst = 1;
    logic        in_valid = 0, in_ready;
    logic [15:0] in_instr = '0, in_pc = '0;
    logic [2:0]  flags = '0;
    logic        flags_busy = 0, wb_en = 0, flush = 0, out_ready = 1;
    logic [3:0]  wb_reg = '0;
    logic [15:0] wb_data = '0;
    logic        out_valid, redirect_valid;
    logic [10:0] out_ctrl;
    logic [3:0]  out_src1, out_src2, out_dst;
    logic [15:0] out_data1, out_data2, out_imm, out_pc, redirect_pc, stall_count;

    int n_cmp = 0, n_err = 0;

    id_stage_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .flags(flags), .flags_busy(flags_busy), .wb_en(wb_en), .wb_reg(wb_reg),
        .wb_data(wb_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_src1(out_src1), .out_src2(out_src2), .out_dst(out_dst),
        .out_data1(out_data1), .out_data2(out_data2), .out_imm(out_imm), .out_pc(out_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_ctrl", out_ctrl, 0);
        check("rst_data1", out_data1, 0);
        check("rst_pc", out_pc, 0);
        check("rst_cnt", stall_count, 0);
        check("rst_redir", redirect_valid, 0);
        rst = 0;

        // write R3 and read it in the same cycle
        in_valid = 1; in_instr = 16'h0530; in_pc = 16'h0002;
        wb_en = 1; wb_reg = 3; wb_data = 16'h1234;
        #1 check("byp_ready", in_ready, 1);
        tick;
        check("byp_valid", out_valid, 1);
        check("byp_data1", out_data1, 16'h1234);
        check("byp_data2", out_data2, 0);
        check("byp_dst", out_dst, 5);
        check("byp_ctrl", out_ctrl, 11'h400);
        check("byp_pc", out_pc, 16'h0002);
        wb_reg = 0; wb_data = 16'hFFFF; in_instr = 16'h0700;
        tick;
        check("r0_data1", out_data1, 0);
        check("r0_data2", out_data2, 0);
        wb_en = 0; in_instr = 16'h0630;
        tick;
        check("r3_kept", out_data1, 16'h1234);
        check("r0_kept", out_data2, 0);

        // immediates: LLB zero-extends [7:0], SLL sign-extends [3:0]
        in_instr = 16'hB9A5;
        tick;
        check("llb_imm", out_imm, 16'h00A5);
        check("llb_ctrl", out_ctrl, 11'h629);
        check("llb_src1", out_src1, 9);
        in_instr = 16'h513F;
        tick;
        check("sll_imm", out_imm, 16'hFFFF);
        check("sll_ctrl", out_ctrl, 11'h605);

        // load-use: LW R2 then ADD R4,R2,R1
        in_instr = 16'h8210;
        tick;
        check("lw_ctrl", out_ctrl, 11'h740);
        check("lw_dst", out_dst, 2);
        in_instr = 16'h0421;
        #1 check("lu_ready", in_ready, 0);
        tick;
        check("lu_bubble", out_valid, 0);
        check("lu_cnt", stall_count, 1);
        check("lu_ready2", in_ready, 1);
        tick;
        check("lu_issue", out_valid, 1);
        check("lu_dst", out_dst, 4);
        check("lu_src1", out_src1, 2);
        check("lu_src2", out_src2, 1);
        check("lu_cnt2", stall_count, 1);

        // B EQ, off=0x1FF -> 0x0010 - 2
        in_instr = 16'hC3FF; in_pc = 16'h0010; flags = 3'b100;
        #1 check("beq_taken", redirect_valid, 1);
        check("beq_pc", redirect_pc, 16'h000E);
        flags = 3'b000;
        #1 check("beq_not", redirect_valid, 0);
        check("beq_ready", in_ready, 1);
        tick;

        // flag stall for two cycles, then an unconditional B to 0x0108
        in_instr = 16'hCE04; in_pc = 16'h0100; flags_busy = 1;
        #1 check("fs_ready", in_ready, 0);
        check("fs_redir", redirect_valid, 0);
        tick;
        check("fs_redir2", redirect_valid, 0);
        tick;
        check("fs_cnt", stall_count, 3);
        flags_busy = 0;
        #1 check("fs_go", redirect_valid, 1);
        check("fs_pc", redirect_pc, 16'h0108);
        tick;

        // BR unconditional through R3
        in_instr = 16'hDE30;
        #1 check("br_taken", redirect_valid, 1);
        check("br_pc", redirect_pc, 16'h1234);
        tick;

        // back-pressure holds ID/EX and does not count
        in_instr = 16'h2833;
        tick;
        check("bp_dst0", out_dst, 8);
        out_ready = 0; in_instr = 16'h0421;
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_ready", in_ready, 0);
            tick;
            check("bp_valid", out_valid, 1);
            check("bp_dst", out_dst, 8);
            check("bp_data1", out_data1, 16'h1234);
        end
        check("bp_cnt", stall_count, 3);
        out_ready = 1;
        #1 check("bp_release", in_ready, 1);
        tick;
        check("bp_next", out_dst, 4);

        // flush during load-use
        in_instr = 16'h8210;
        tick;
        in_instr = 16'h0421; flush = 1;
        #1 check("fl_ready", in_ready, 0);
        check("fl_redir", redirect_valid, 0);
        tick;
        check("fl_valid", out_valid, 0);
        flush = 0;
        tick;
        check("fl_after", out_valid, 1);
        in_instr = 16'hCE04; flush = 1;
        #1 check("fl_br", redirect_valid, 0);
        out_ready = 0;
        tick;
        check("fl_bp", out_valid, 0);
        flush = 0; out_ready = 1;

        // async reset in the middle of a flag stall under back-pressure
        in_instr = 16'h2833;
        tick;
        out_ready = 0; in_instr = 16'hCE04; flags_busy = 1;
        tick;
        check("mr_cnt", stall_count, 4);
        check("mr_valid", out_valid, 1);
        #2 rst = 1;
        #1;
        check("mr_valid0", out_valid, 0);
        check("mr_cnt0", stall_count, 0);
        check("mr_dst0", out_dst, 0);
        check("mr_data0", out_data1, 0);
        check("mr_ctrl0", out_ctrl, 0);
        check("mr_redir", redirect_valid, 0);
        #1 rst = 0;
        flags_busy = 0; out_ready = 1; in_instr = 16'h0533;
        tick;
        check("mr_rf_clr", out_data1, 0);
        check("mr_valid1", out_valid, 1);

        in_valid = 0;
        tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
